mcs4_cycle_sequencer: RTL and testbench
=======================================

// Module: mcs4_cycle_sequencer
// PURPOSE
// - Parametrised MCS-4 bus-side cycle sequencer: generates the two-phase non-overlapping clk1/clk2, SYNC and the
//   8-subcycle instruction frame (A1..X3) from sysclk, replacing external clock pads.
// - Captures address/opcode nibbles from the 4-bit bus; drives CM-ROM and N CM-RAM bank strobes.
// - Adds run/single-step mode; feeds the timing/IO board and an on-chip ROM/RAM model.
// PARAMETERS
// - CLK_DIV  2  sysclk cycles per phase slot (>=1)
// - N_CMRAM  4  CM-RAM bank lines (1..8)
// - BANK_W   $clog2(N_CMRAM) (min 1)  width of bank_sel
// PORTS
// - sysclk      in   1        system clock, all logic on rising edge
// - rst_n       in   1        asynchronous active-low reset
// - run         in   1        1 = free-run; 0 = stop at end of current X3
// - step        in   1        1-sysclk pulse: execute one instruction cycle when halted
// - data_in     in   4        bus nibble from data pads
// - bank_sel    in   BANK_W   CM-RAM bank selected by DCL
// - src_cycle   in   1        current instruction is SRC (sampled at start of X2)
// - clk1,clk2   out  1        non-overlapping phase clocks
// - sync        out  1        high for the whole X3 subcycle
// - subcycle    out  3        current subcycle, A1=0..X3=7
// - addr        out  12       fetched address {A3,A2,A1 nibbles}
// - opcode      out  8        {OPR (M1), OPA (M2)}
// - fetch_valid out  1        1-sysclk pulse: addr/opcode valid
// - cm_rom      out  1        CM-ROM strobe
// - cm_ram      out  N_CMRAM  one-hot CM-RAM strobes
// - halted      out  1        sequencer stopped between X3 and A1
// BEHAVIOUR
// - Reset: clk1=clk2=sync=0, subcycle=7, addr=0, opcode=0, fetch_valid=0, cm_rom=0, cm_ram=0, halted=1. Reset
//   mid-cycle aborts immediately; nothing is completed.
// - Subcycle = 4 slots of CLK_DIV sysclks: slot0 clk1=1, slot1 gap, slot2 clk2=1, slot3 gap. Subcycle = 4*CLK_DIV
//   sysclks; instruction cycle = 32*CLK_DIV.
// - All outputs are registered and change only on slot boundaries, except fetch_valid.
// - data_in is sampled on the last sysclk of slot2 (clk2 high):
//   - A1 -> addr[3:0]; A2 -> addr[7:4]; A3 -> addr[11:8].
//   - M1 -> opcode[7:4]; M2 -> opcode[3:0].
// - addr/opcode update only at the M2 sample; all five nibbles are staged internally.
// - fetch_valid pulses on the sysclk after the M2 sample.
// - cm_rom: high for all of A3; also high for all of X2 when src_cycle=1.
// - cm_ram[bank_sel]: same windows as cm_rom. bank_sel is latched at A1 entry.
//   - bank_sel >= N_CMRAM -> cm_ram stays 0 for that cycle; cm_rom is unaffected.
// - State machine: HALT, RUN, STEP.
//   - HALT -> RUN when run=1. HALT -> STEP on step pulse. Entry lands at A1 slot0 on the next sysclk.
//   - RUN: at end of X3, go to A1 if run=1, else HALT.
//   - STEP: always -> HALT at end of X3.
//   - step while RUN/STEP is ignored. run and step together in HALT: run wins.
//   - Deasserting run mid-cycle completes the cycle through X3, then halts.
// - HALT: clk1=clk2=sync=cm_*=0, subcycle=7, halted=1; addr/opcode hold. halted=0 from the first A1 sysclk.
// - Wrap: subcycle 7 -> 0, slot 3 -> 0, divider CLK_DIV-1 -> 0. No other wrap.
// STRUCTURE
// - mcs4_pkg: localparams SC_A1..SC_X3 (0..7), SLOT_CLK1=0, SLOT_CLK2=2, state encodings HALT/RUN/STEP.
// - Sub-module mcs4_phase_gen(CLK_DIV): divider + slot counter.
//   - Outputs: slot[1:0], slot_last (last sysclk of slot), sub_last (slot3 last).
//   - Enable input gates counting; counters are held at 0 in HALT.
// - Top: FSM, subcycle counter, nibble staging, CM decode, output registers.
// TESTING
// - Reset then run=1, CLK_DIV=2 -> first clk1 rise 1 sysclk after run; clk1 high 2 sysclks, 2 low, clk2 high 2;
//   clk1&clk2 never both 1.
// - Drive nibbles 4,3,2 (A1..A3), 0xD,0x5 (M1,M2) -> addr=0x234, opcode=0xD5, fetch_valid one sysclk after the
//   M2 clk2 sample.
// - bank_sel=2, src_cycle=1 -> cm_rom and cm_ram=4'b0100 high during A3 and X2; cm_ram=0 with bank_sel=5
//   (N_CMRAM=4).
// - run=0, step pulse -> exactly one 64-sysclk cycle (CLK_DIV=2), sync high for the last 8 sysclks, then
//   halted=1; a second step mid-cycle is ignored.
// - run dropped at M1 -> cycle completes through X3, halted=1, addr/opcode hold; rst_n low at A2 -> all outputs
//   at reset values asynchronously.
// - CLK_DIV=1, N_CMRAM=1 build: 32-sysclk cycle, cm_ram[0] follows cm_rom whenever bank_sel=0.

Source files
------------

// File: rtl/mcs4_pkg.sv
// Shared constants for the MCS-4 cycle sequencer.
//   SC_*      : subcycle numbering of the 8-subcycle instruction frame (A1=0 .. X3=7)
//   SLOT_*    : phase-slot numbers inside one subcycle
//   seq_state_e : run-control state machine encoding
package mcs4_pkg;

  localparam logic [2:0] SC_A1 = 3'd0;
  localparam logic [2:0] SC_A2 = 3'd1;
  localparam logic [2:0] SC_A3 = 3'd2;
  localparam logic [2:0] SC_M1 = 3'd3;
  localparam logic [2:0] SC_M2 = 3'd4;
  localparam logic [2:0] SC_X1 = 3'd5;
  localparam logic [2:0] SC_X2 = 3'd6;
  localparam logic [2:0] SC_X3 = 3'd7;

  localparam logic [1:0] SLOT_CLK1 = 2'd0;
  localparam logic [1:0] SLOT_CLK2 = 2'd2;
  localparam logic [1:0] SLOT_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/mcs4_phase_gen.sv
// Phase-slot generator: a CLK_DIV divider feeding a 4-slot counter.
// Ports:
//   sysclk, rst_n : clock / async active-low reset
//   en_i          : count enable; when low both counters are forced to 0
//   slot_o        : current slot (0=clk1, 1=gap, 2=clk2, 3=gap)
//   slot_nxt_o    : slot value after the coming sysclk edge
//   slot_last_o   : this sysclk is the last one of the current slot
//   sub_last_o    : this sysclk is the last one of slot 3 (end of subcycle)
module mcs4_phase_gen
  import mcs4_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [1:0] slot_o,
  output logic [1:0] slot_nxt_o,
  output logic       slot_last_o,
  output logic       sub_last_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       slot_q, slot_d;

  assign slot_last_o = en_i && (div_q == DIV_MAX);
  assign sub_last_o  = slot_last_o && (slot_q == SLOT_LAST);
  assign slot_o      = slot_q;
  assign slot_nxt_o  = slot_d;

  always_comb begin
    div_d  = '0;
    slot_d = '0;
    if (en_i) begin
      div_d  = slot_last_o ? '0 : div_q + DIV_W'(1);
      // 2-bit slot counter wraps 3 -> 0 on its own
      slot_d = slot_last_o ? slot_q + 2'd1 : slot_q;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      slot_q <= '0;
    end else begin
      div_q  <= div_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/mcs4_cycle_sequencer.sv
// MCS-4 bus-side cycle sequencer: generates clk1/clk2, SYNC and the A1..X3
// frame from sysclk, captures address/opcode nibbles and drives CM strobes.
// Ports:
//   sysclk, rst_n         : clock / async active-low reset
//   run, step             : free-run level / single-instruction pulse
//   data_in               : 4-bit bus nibble
//   bank_sel, src_cycle   : CM-RAM bank (latched at A1 entry) / SRC flag (X2 entry)
//   clk1, clk2, sync      : phase clocks and X3 marker
//   subcycle              : A1=0 .. X3=7 (7 while halted)
//   addr, opcode          : last fetched address and opcode
//   fetch_valid           : one-sysclk pulse after the M2 sample
//   cm_rom, cm_ram        : command strobes
//   halted                : sequencer stopped between X3 and A1
//   dbg_state             : run-control FSM state
//
// Handshake: there is no backpressure. fetch_valid is a one-sysclk qualifier;
// addr/opcode are valid from that sysclk and hold until the next M2 sample.
//
// All outputs are registered from the next-state position so that they
// change exactly on slot boundaries together with the counters.
module mcs4_cycle_sequencer
  import mcs4_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int N_CMRAM = 4,
  parameter int BANK_W  = (N_CMRAM > 1) ? $clog2(N_CMRAM) : 1
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic [3:0]        data_in,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic              src_cycle,
  output logic              clk1,
  output logic              clk2,
  output logic              sync,
  output logic [2:0]        subcycle,
  output logic [11:0]       addr,
  output logic [7:0]        opcode,
  output logic              fetch_valid,
  output logic              cm_rom,
  output logic [N_CMRAM-1:0] cm_ram,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  seq_state_e state_q, state_d;
  logic [2:0] sub_q, sub_d;
  logic [1:0] slot, slot_nxt;
  logic       slot_last, sub_last;
  logic       en, end_x3, active_d, enter_a1, enter_x2, sample;

  logic [3:0] a1_q, a2_q, a3_q, m1_q;
  logic [BANK_W-1:0] bank_q, bank_eff;
  logic       src_q, src_eff;

  logic clk1_q, clk1_d, clk2_q, clk2_d, sync_q, sync_d, rom_q, rom_d, halted_q, halted_d;
  logic [2:0] subcycle_q, subcycle_d;
  logic [N_CMRAM-1:0] ram_q, ram_d;
  logic [11:0] addr_q;
  logic [7:0]  opcode_q;
  logic        fv_q;

  assign en     = (state_q != ST_HALT);
  assign end_x3 = sub_last && (sub_q == SC_X3);
  assign sample = slot_last && (slot == SLOT_CLK2);

  mcs4_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .en_i        (en),
    .slot_o      (slot),
    .slot_nxt_o  (slot_nxt),
    .slot_last_o (slot_last),
    .sub_last_o  (sub_last)
  );

  // FSM: state register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HALT;
    else        state_q <= state_d;
  end

  // FSM: next state. run has priority over step when halted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (run)       state_d = ST_RUN;
        else if (step) state_d = ST_STEP;
      end
      ST_RUN:  if (end_x3) state_d = run ? ST_RUN : ST_HALT;
      ST_STEP: if (end_x3) state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // Subcycle advances at the end of each slot 3; the 3-bit wrap gives X3 -> A1.
  always_comb begin
    sub_d = '0;
    if (en) sub_d = sub_last ? sub_q + 3'd1 : sub_q;
  end

  assign active_d = (state_d != ST_HALT);
  assign enter_a1 = active_d && (!en || end_x3);
  assign enter_x2 = sub_last && (sub_q == SC_X1);
  // Use the live input on the entry edge so the strobe starts with the subcycle.
  assign bank_eff = enter_a1 ? bank_sel : bank_q;
  assign src_eff  = enter_x2 ? src_cycle : src_q;

  // FSM: output decode from the next position
  always_comb begin
    clk1_d     = active_d && (slot_nxt == SLOT_CLK1);
    clk2_d     = active_d && (slot_nxt == SLOT_CLK2);
    sync_d     = active_d && (sub_d == SC_X3);
    subcycle_d = active_d ? sub_d : SC_X3;
    halted_d   = !active_d;
    rom_d      = active_d && ((sub_d == SC_A3) || ((sub_d == SC_X2) && src_eff));
    ram_d      = '0;
    if (rom_d && (32'(bank_eff) < N_CMRAM)) ram_d = N_CMRAM'(1) << bank_eff;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q      <= SC_X3;
      bank_q     <= '0;
      src_q      <= 1'b0;
      clk1_q     <= 1'b0;
      clk2_q     <= 1'b0;
      sync_q     <= 1'b0;
      subcycle_q <= SC_X3;
      halted_q   <= 1'b1;
      rom_q      <= 1'b0;
      ram_q      <= '0;
    end else begin
      sub_q      <= sub_d;
      if (enter_a1) bank_q <= bank_sel;
      if (enter_x2) src_q  <= src_cycle;
      clk1_q     <= clk1_d;
      clk2_q     <= clk2_d;
      sync_q     <= sync_d;
      subcycle_q <= subcycle_d;
      halted_q   <= halted_d;
      rom_q      <= rom_d;
      ram_q      <= ram_d;
    end
  end

  // Nibble staging: sampled on the last sysclk of the clk2 slot.
  // addr/opcode are published together only at the M2 sample.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q     <= '0;
      a2_q     <= '0;
      a3_q     <= '0;
      m1_q     <= '0;
      addr_q   <= '0;
      opcode_q <= '0;
      fv_q     <= 1'b0;
    end else begin
      fv_q <= sample && (sub_q == SC_M2);
      if (sample) begin
        case (sub_q)
          SC_A1: a1_q <= data_in;
          SC_A2: a2_q <= data_in;
          SC_A3: a3_q <= data_in;
          SC_M1: m1_q <= data_in;
          SC_M2: begin
            addr_q   <= {a3_q, a2_q, a1_q};
            opcode_q <= {m1_q, data_in};
          end
          default: ;
        endcase
      end
    end
  end

  assign clk1        = clk1_q;
  assign clk2        = clk2_q;
  assign sync        = sync_q;
  assign subcycle    = subcycle_q;
  assign addr        = addr_q;
  assign opcode      = opcode_q;
  assign fetch_valid = fv_q;
  assign cm_rom      = rom_q;
  assign cm_ram      = ram_q;
  assign halted      = halted_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mcs4_cycle_sequencer.sv
module tb_mcs4_cycle_sequencer;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Instance A: CLK_DIV=2, N_CMRAM=4, 3-bit bank_sel so out-of-range banks are reachable
  logic        rst_n, run, step, src_cycle;
  logic [3:0]  data_in;
  logic [2:0]  bank_sel;
  logic        clk1, clk2, sync, fetch_valid, cm_rom, halted;
  logic [2:0]  subcycle;
  logic [11:0] addr;
  logic [7:0]  opcode;
  logic [3:0]  cm_ram;
  logic [1:0]  dbg_state;

  mcs4_cycle_sequencer #(.CLK_DIV(2), .N_CMRAM(4), .BANK_W(3)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .run(run), .step(step), .data_in(data_in),
    .bank_sel(bank_sel), .src_cycle(src_cycle), .clk1(clk1), .clk2(clk2), .sync(sync),
    .subcycle(subcycle), .addr(addr), .opcode(opcode), .fetch_valid(fetch_valid),
    .cm_rom(cm_rom), .cm_ram(cm_ram), .halted(halted), .dbg_state(dbg_state)
  );

  // Instance B: CLK_DIV=1, N_CMRAM=1
  logic        rst_n_b, run_b, step_b, src_b, bank_b;
  logic [3:0]  data_b;
  logic        clk1_b, clk2_b, sync_b, fv_b, rom_b, halted_b;
  logic [2:0]  sub_b;
  logic [11:0] addr_b;
  logic [7:0]  op_b;
  logic [0:0]  ram_b;
  logic [1:0]  dbg_b;

  mcs4_cycle_sequencer #(.CLK_DIV(1), .N_CMRAM(1)) dut_b (
    .sysclk(sysclk), .rst_n(rst_n_b), .run(run_b), .step(step_b), .data_in(data_b),
    .bank_sel(bank_b), .src_cycle(src_b), .clk1(clk1_b), .clk2(clk2_b), .sync(sync_b),
    .subcycle(sub_b), .addr(addr_b), .opcode(op_b), .fetch_valid(fv_b),
    .cm_rom(rom_b), .cm_ram(ram_b), .halted(halted_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          k;
    logic        c1, c2, sy;
    logic [2:0]  sc;
    logic        rom;
    logic [3:0]  ram;
    logic        fv, hl;
    logic [11:0] ad;
    logic [7:0]  op;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int k, logic c1, logic c2, logic sy, logic [2:0] sc, logic rom,
                              logic [3:0] ram, logic fv, logic hl, logic [11:0] ad, logic [7:0] op);
    vec_t v;
    v.k = k; v.c1 = c1; v.c2 = c2; v.sy = sy; v.sc = sc; v.rom = rom;
    v.ram = ram; v.fv = fv; v.hl = hl; v.ad = ad; v.op = op;
    return v;
  endfunction

  // nibbles presented during each subcycle of two back-to-back cycles
  logic [3:0] nib [16] = '{4'h4, 4'h3, 4'h2, 4'hD, 4'h5, 4'h0, 4'h0, 4'h0,
                           4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h0, 4'h0, 4'h0};

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge sysclk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_clk1"}, clk1, 0);
    chk({tag, "_clk2"}, clk2, 0);
    chk({tag, "_sync"}, sync, 0);
    chk({tag, "_sub"}, subcycle, 7);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_opcode"}, opcode, 0);
    chk({tag, "_fv"}, fetch_valid, 0);
    chk({tag, "_rom"}, cm_rom, 0);
    chk({tag, "_ram"}, cm_ram, 0);
    chk({tag, "_halted"}, halted, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act_cnt, sync_cnt, rom_cnt, ram_cnt;
    bit found;

    // Cycle 1: bank 2, SRC, fetch 0x234/0xD5. Cycle 2: bank 5, run dropped at M1.
    tbl.push_back(mk(0,   1,0,0, 0, 0,4'h0, 0,0, 12'h000, 8'h00));
    tbl.push_back(mk(1,   1,0,0, 0, 0,4'h0, 0,0, 12'h000, 8'h00));
    tbl.push_back(mk(2,   0,0,0, 0, 0,4'h0, 0,0, 12'h000, 8'h00));
    tbl.push_back(mk(4,   0,1,0, 0, 0,4'h0, 0,0, 12'h000, 8'h00));
    tbl.push_back(mk(7,   0,0,0, 0, 0,4'h0, 0,0, 12'h000, 8'h00));
    tbl.push_back(mk(16,  1,0,0, 2, 1,4'h4, 0,0, 12'h000, 8'h00));
    tbl.push_back(mk(23,  0,0,0, 2, 1,4'h4, 0,0, 12'h000, 8'h00));
    tbl.push_back(mk(24,  1,0,0, 3, 0,4'h0, 0,0, 12'h000, 8'h00));
    tbl.push_back(mk(37,  0,1,0, 4, 0,4'h0, 0,0, 12'h000, 8'h00));
    tbl.push_back(mk(38,  0,0,0, 4, 0,4'h0, 1,0, 12'h234, 8'hD5));
    tbl.push_back(mk(39,  0,0,0, 4, 0,4'h0, 0,0, 12'h234, 8'hD5));
    tbl.push_back(mk(48,  1,0,0, 6, 1,4'h4, 0,0, 12'h234, 8'hD5));
    tbl.push_back(mk(55,  0,0,0, 6, 1,4'h4, 0,0, 12'h234, 8'hD5));
    tbl.push_back(mk(56,  1,0,1, 7, 0,4'h0, 0,0, 12'h234, 8'hD5));
    tbl.push_back(mk(63,  0,0,1, 7, 0,4'h0, 0,0, 12'h234, 8'hD5));
    tbl.push_back(mk(64,  1,0,0, 0, 0,4'h0, 0,0, 12'h234, 8'hD5));
    tbl.push_back(mk(80,  1,0,0, 2, 1,4'h0, 0,0, 12'h234, 8'hD5));
    tbl.push_back(mk(102, 0,0,0, 4, 0,4'h0, 1,0, 12'h321, 8'h45));
    tbl.push_back(mk(112, 1,0,0, 6, 1,4'h0, 0,0, 12'h321, 8'h45));
    tbl.push_back(mk(120, 1,0,1, 7, 0,4'h0, 0,0, 12'h321, 8'h45));
    tbl.push_back(mk(127, 0,0,1, 7, 0,4'h0, 0,0, 12'h321, 8'h45));
    tbl.push_back(mk(128, 0,0,0, 7, 0,4'h0, 0,1, 12'h321, 8'h45));
    tbl.push_back(mk(129, 0,0,0, 7, 0,4'h0, 0,1, 12'h321, 8'h45));

    exp_q.push_back({12'h234, 8'hD5});
    exp_q.push_back({12'h321, 8'h45});

    // ---- reset ----
    rst_n = 0; run = 0; step = 0; src_cycle = 0; data_in = 0; bank_sel = 0;
    rst_n_b = 0; run_b = 0; step_b = 0; src_b = 0; bank_b = 0; data_b = 0;
    #12;
    check_reset_values("reset");
    @(negedge sysclk);
    rst_n = 1; rst_n_b = 1;
    idle_cycles(3);
    chk("idle_halted", halted, 1);
    chk("idle_sub", subcycle, 7);
    chk("idle_clk1", clk1, 0);

    // ---- free run, two cycles, table-driven ----
    run = 1; bank_sel = 3'd2; src_cycle = 1; data_in = nib[0];
    for (int k = 0; k < 130; k++) begin
      @(negedge sysclk);
      foreach (tbl[j]) begin
        if (tbl[j].k == k) begin
          chk($sformatf("clk1@%0d", k), clk1, tbl[j].c1);
          chk($sformatf("clk2@%0d", k), clk2, tbl[j].c2);
          chk($sformatf("sync@%0d", k), sync, tbl[j].sy);
          chk($sformatf("sub@%0d", k), subcycle, tbl[j].sc);
          chk($sformatf("rom@%0d", k), cm_rom, tbl[j].rom);
          chk($sformatf("ram@%0d", k), cm_ram, tbl[j].ram);
          chk($sformatf("fv@%0d", k), fetch_valid, tbl[j].fv);
          chk($sformatf("halted@%0d", k), halted, tbl[j].hl);
          chk($sformatf("addr@%0d", k), addr, tbl[j].ad);
          chk($sformatf("opcode@%0d", k), opcode, tbl[j].op);
        end
      end
      chk($sformatf("overlap@%0d", k), clk1 & clk2, 0);
      if (fetch_valid) begin
        chk($sformatf("fetch_expected@%0d", k), exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk($sformatf("fetch@%0d", k), {addr, opcode}, exp_q.pop_front());
      end
      if (k == 63) bank_sel = 3'd5;
      if (k == 88) run = 0;
      data_in = nib[((k + 1) / 8) % 16];
    end
    chk("fetch_outstanding", exp_q.size(), 0);

    // ---- single step, second step mid-cycle ignored ----
    act_cnt = 0; sync_cnt = 0;
    step = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge sysclk);
      if (k == 0) step = 0;
      if (k == 20) step = 1;
      if (k == 21) step = 0;
      act_cnt += int'(!halted);
      sync_cnt += int'(sync);
      if (k == 63) chk("step_last_active", halted, 0);
      if (k == 64) chk("step_halts", halted, 1);
      chk($sformatf("step_overlap@%0d", k), clk1 & clk2, 0);
    end
    chk("step_len", act_cnt, 64);
    chk("step_sync_len", sync_cnt, 8);
    chk("step_end_sub", subcycle, 7);

    // ---- async reset during A2 ----
    run = 1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge sysclk);
      if (subcycle == 3'd1) found = 1;
    end
    chk("reach_a2", found, 1);
    chk("a2_clk1_before_reset", clk1, 1);
    #1 rst_n = 0;
    #1 check_reset_values("async");
    run = 0;
    @(negedge sysclk);
    rst_n = 1;
    idle_cycles(2);
    chk("post_reset_halted", halted, 1);

    // ---- CLK_DIV=1, N_CMRAM=1 build ----
    for (int pass = 0; pass < 2; pass++) begin
      act_cnt = 0; rom_cnt = 0; ram_cnt = 0;
      bank_b = pass[0]; src_b = 1; step_b = 1;
      for (int k = 0; k < 40; k++) begin
        @(negedge sysclk);
        if (k == 0) step_b = 0;
        act_cnt += int'(!halted_b);
        rom_cnt += int'(rom_b);
        ram_cnt += int'(ram_b[0]);
        if (pass == 0) chk($sformatf("b_ram_follows@%0d", k), ram_b[0], rom_b);
      end
      chk($sformatf("b_len_p%0d", pass), act_cnt, 32);
      chk($sformatf("b_rom_p%0d", pass), rom_cnt, 8);
      chk($sformatf("b_ram_p%0d", pass), ram_cnt, (pass == 0) ? 8 : 0);
      chk($sformatf("b_halted_p%0d", pass), halted_b, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
